vector_mem_responder: RTL
=========================

// Module: vector_mem_responder
// PURPOSE
//  Memory-side responder for the vector address scheduler's single serialized port. Accepts one
//  element access per handshake (final_addr/final_storedata/ren/wen/sew) and replays it on the
//  generic data bus with SEW-derived byte enables and lane shifting. Returns dhit plus aligned load
//  data, or returnex on fault. Sits between the scheduler and the dcache/bus arbiter.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max cycles in ACCESS with bus_busy high before returnex; 0 disables timeout
// PORTS
//  CLK              in   1   clock, all state on rising edge
//  nRST             in   1   asynchronous, active-low reset
//  final_addr       in   32  element byte address from scheduler
//  final_storedata  in   32  element store data, right-justified (bits [SEW-1:0] valid)
//  ren              in   1   load request
//  wen              in   1   store request
//  sew              in   2   sew_t element width (SEW8/SEW16/SEW32; other encoding reserved)
//  dhit             out  1   one-cycle pulse: access complete
//  loaddata         out  32  load element, right-justified, zero-extended; valid when dhit=1
//  returnex         out  1   one-cycle pulse: access faulted, no bus side effect beyond any started
//  bus_addr         out  32  word-aligned address {final_addr[31:2],2'b00}
//  bus_wdata        out  32  storedata shifted left by 8*addr[1:0]
//  bus_byte_en      out  4   byte enables
//  bus_ren/bus_wen  out  1   bus request strobes, held until bus_busy=0
//  bus_rdata        in   32  bus read data, valid when bus_busy=0
//  bus_busy         in   1   bus stall; access completes in the first ACCESS cycle it is low
// BEHAVIOUR
//  Reset (async, nRST=0): state=IDLE; dhit=0, returnex=0, loaddata=0, bus_ren=0, bus_wen=0,
//   bus_addr=0, bus_wdata=0, bus_byte_en=0; timeout counter=0. Outputs drop as reset asserts,
//   including mid-ACCESS; the aborted access is never reported.
//  States: IDLE, ACCESS, RESP, FAULT.
//  IDLE: ren^wen=1 -> latch addr/data/sew/dir. Misaligned (SEW16 & addr[0]; SEW32 & addr[1:0]!=0)
//   or reserved sew -> FAULT, else -> ACCESS. ren&wen=1 -> FAULT. Neither -> stay.
//  ACCESS: drive bus from latched regs. bus_busy=0 -> capture rdata (loads), -> RESP.
//   bus_busy=1 -> counter++; counter reaches TIMEOUT_CYCLES-1 while still busy -> FAULT.
//  RESP: dhit=1 for exactly one cycle, loaddata valid; -> IDLE. Scheduler advances its request in
//   this cycle; IDLE samples the next request the following cycle (no back-to-back reuse of a hit).
//  FAULT: returnex=1 for one cycle, bus strobes low; -> IDLE.
//  Latency: request seen in IDLE cycle N, bus strobe in N+1; zero-wait bus -> dhit in N+2.
//   Throughput: one element per (3 + bus wait states) cycles.
//  Byte enable: SEW8 4'b0001<<a[1:0]; SEW16 4'b0011<<a[1:0]; SEW32 4'b1111.
//  Load align: loaddata = (bus_rdata >> 8*a[1:0]) masked to SEW, upper bits zero.
//  Inputs changed while not IDLE are ignored (request latched). dhit and returnex never coincide.
//  Counter clears on every IDLE entry; counter width $clog2(TIMEOUT_CYCLES+1).
// STRUCTURE
//  rv32v_types_pkg: add vmem_resp_state_t enum {IDLE,ACCESS,RESP,FAULT}; reuse sew_t.
//  Sub-module vector_lane_align (combinational): sew + addr[1:0] -> byte_en, wdata shift,
//   rdata shift/mask, misalign flag. FSM, latches and timeout counter stay in this module.
// TESTING
//  SEW32 load 0x1000, bus busy 0 -> bus_ren in N+1, byte_en=4'hF, dhit N+2, loaddata=bus_rdata.
//  SEW8 store addr 0x2003 data 0xAB -> bus_addr 0x2000, byte_en 4'b1000, wdata 0xAB000000, dhit.
//  SEW16 load addr 0x3002, rdata 0xBEEF1234, busy 3 cycles -> loaddata 0x0000BEEF, dhit N+5.
//  SEW32 addr 0x1001, then ren&wen together -> returnex pulses, bus strobes never assert.
//  TIMEOUT_CYCLES=4, bus_busy stuck 1 -> returnex after 4 ACCESS cycles, back to IDLE, no dhit.
//  nRST low mid-ACCESS -> bus_ren drops immediately, no dhit/returnex after release; next req ok.

Source files
------------

// File: rtl/vector_mem_responder_pkg.sv
// rtl/vector_mem_responder_pkg.sv - shared types for the vector memory responder
package vector_mem_responder_pkg;

  typedef enum logic [1:0] {
    SEW8     = 2'b00,
    SEW16    = 2'b01,
    SEW32    = 2'b10,
    SEW_RSVD = 2'b11
  } sew_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10,
    FAULT  = 2'b11
  } vmem_resp_state_t;

  localparam int unsigned XLEN = 32;

  // Element bit mask; the reserved width yields an empty mask.
  function automatic logic [XLEN-1:0] sew_mask(input sew_t s);
    case (s)
      SEW8:    sew_mask = 32'h0000_00FF;
      SEW16:   sew_mask = 32'h0000_FFFF;
      SEW32:   sew_mask = 32'hFFFF_FFFF;
      default: sew_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/vector_mem_responder_if.sv
// rtl/vector_mem_responder_if.sv - scheduler request/response and generic data bus bundle
interface vector_mem_responder_if;
  import vector_mem_responder_pkg::*;

  logic [31:0] final_addr;
  logic [31:0] final_storedata;
  logic        ren;
  logic        wen;
  sew_t        sew;
  logic        dhit;
  logic [31:0] loaddata;
  logic        returnex;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byte_en;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_rdata;
  logic        bus_busy;

  modport slave (
    input  final_addr, final_storedata, ren, wen, sew, bus_rdata, bus_busy,
    output dhit, loaddata, returnex, bus_addr, bus_wdata, bus_byte_en, bus_ren, bus_wen
  );

  modport master (
    output final_addr, final_storedata, ren, wen, sew, bus_rdata, bus_busy,
    input  dhit, loaddata, returnex, bus_addr, bus_wdata, bus_byte_en, bus_ren, bus_wen
  );

endinterface

// File: rtl/vector_mem_responder_lane_align.sv
// rtl/vector_mem_responder_lane_align.sv - SEW/offset byte enables, lane shifts and alignment check
module vector_mem_responder_lane_align
  import vector_mem_responder_pkg::*;
(
  input  sew_t        i_sew,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_illegal
);

  logic [31:0] w_mask;
  logic [4:0]  w_shamt;

  always_comb begin
    w_shamt   = {i_addr_lo, 3'b000};
    w_mask    = sew_mask(i_sew);
    o_byte_en = 4'b0000;
    o_illegal = 1'b0;
    case (i_sew)
      SEW8:  o_byte_en = 4'b0001 << i_addr_lo;
      SEW16: begin
        o_byte_en = 4'b0011 << i_addr_lo;
        o_illegal = i_addr_lo[0];
      end
      SEW32: begin
        o_byte_en = 4'b1111;
        o_illegal = |i_addr_lo;
      end
      default: o_illegal = 1'b1;
    endcase
    // Store data is masked first so stray upper bits never reach other lanes.
    o_wdata = (i_wdata & w_mask) << w_shamt;
    o_rdata = (i_rdata >> w_shamt) & w_mask;
  end

endmodule

// File: rtl/vector_mem_responder.sv
// rtl/vector_mem_responder.sv - replays one scheduler element access on the data bus, reports hit or fault
module vector_mem_responder
  import vector_mem_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  CLK,
  input  logic                  nRST,
  vector_mem_responder_if.slave vif
);

  localparam int unsigned CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

  vmem_resp_state_t r_state, w_next;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic [31:0]      r_loaddata;
  sew_t             r_sew;
  logic             r_is_store;
  logic [CW-1:0]    r_count;

  sew_t        w_sel_sew;
  logic [1:0]  w_sel_lo;
  logic [3:0]  w_byte_en;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic        w_illegal;
  logic        w_req;
  logic        w_both;
  logic        w_timeout;
  logic        w_access;

  // One aligner serves both phases: IDLE checks the incoming request, later states use the latch.
  always_comb begin
    if (r_state == IDLE) begin
      w_sel_sew = vif.sew;
      w_sel_lo  = vif.final_addr[1:0];
    end else begin
      w_sel_sew = r_sew;
      w_sel_lo  = r_addr[1:0];
    end
  end

  vector_mem_responder_lane_align u_align (
    .i_sew     (w_sel_sew),
    .i_addr_lo (w_sel_lo),
    .i_wdata   (r_data),
    .i_rdata   (vif.bus_rdata),
    .o_byte_en (w_byte_en),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata),
    .o_illegal (w_illegal)
  );

  assign w_req     = vif.ren ^ vif.wen;
  assign w_both    = vif.ren & vif.wen;
  assign w_timeout = TO_EN && (r_count == C_LAST);
  assign w_access  = (r_state == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_both)     w_next = FAULT;
        else if (w_req) w_next = w_illegal ? FAULT : ACCESS;
      end
      ACCESS: begin
        if (!vif.bus_busy) w_next = RESP;
        else if (w_timeout) w_next = FAULT;
      end
      RESP:    w_next = IDLE;
      FAULT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_sew      <= SEW8;
      r_is_store <= 1'b0;
      r_loaddata <= '0;
      r_count    <= '0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_addr     <= vif.final_addr;
        r_data     <= vif.final_storedata;
        r_sew      <= vif.sew;
        r_is_store <= vif.wen;
      end
      if (w_access && !vif.bus_busy) r_loaddata <= r_is_store ? '0 : w_rdata;
      if (w_access && vif.bus_busy)  r_count <= r_count + CW'(1);
      else                           r_count <= '0;
    end
  end

  // Bus side is purely a function of state so reset drops the strobes without waiting for a clock.
  always_comb begin
    vif.bus_ren     = w_access & ~r_is_store;
    vif.bus_wen     = w_access & r_is_store;
    vif.bus_addr    = w_access ? {r_addr[31:2], 2'b00} : 32'h0;
    vif.bus_wdata   = (w_access && r_is_store) ? w_wdata : 32'h0;
    vif.bus_byte_en = w_access ? w_byte_en : 4'b0000;
    vif.dhit        = (r_state == RESP);
    vif.returnex    = (r_state == FAULT);
    vif.loaddata    = (r_state == RESP) ? r_loaddata : 32'h0;
  end

endmodule
